l2_cache_control_nway: RTL

- Parametrised successor to the 4-way L2 controller.
- Drives an N-way set-associative, write-back, write-allocate L2 datapath with multi-beat physical-memory bursts.
- Selects victims by preferring an invalid way, otherwise the PLRU way supplied by the datapath.
- Sits between the L1/arbiter request port and physical memory; tag/data/dirty/PLRU arrays live in the datapath.

---
 rtl/l2_cache_control_nway.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/l2_cache_control_nway.sv
// l2_cache_control_nway: N-way write-back/write-allocate L2 controller FSM driving a burst pmem.
// Define L2_PERF_CNT_EN to add saturating hit/miss/writeback counters.
module l2_cache_control_nway #(
  parameter int WAYS      = 4,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 32,
  localparam int WIDX     = $clog2(WAYS),
  localparam int BW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_read,
  input  logic            mem_write,
  output logic            mem_resp,
  input  logic [WAYS-1:0] hit_vec,
  input  logic [WAYS-1:0] valid_vec,
  input  logic [WAYS-1:0] dirty_vec,
  input  logic [WIDX-1:0] plru_victim,
  input  logic            pmem_resp,
  output logic            pmem_read,
  output logic            pmem_write,
  output logic [BW-1:0]   beat_idx,
  output logic            addr_sel,
  output logic [WIDX-1:0] way_sel,
  output logic [WAYS-1:0] ld_data,
  output logic [WAYS-1:0] ld_tag,
  output logic [WAYS-1:0] ld_valid,
  output logic [WAYS-1:0] ld_dirty,
  output logic            data_src_sel,
  output logic            dirty_in,
  output logic            ld_plru
`ifdef L2_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
`endif
);

  typedef enum logic [1:0] {IDLE, LOOKUP, WB, FILL} state_t;

  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  function automatic logic [WIDX-1:0] lowest_idx(input logic [WAYS-1:0] v);
    logic [WIDX-1:0] idx;
    idx = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (v[i]) idx = WIDX'(i);
    end
    return idx;
  endfunction

  state_t          state, state_d;
  logic [BW-1:0]   cnt;
  logic [WIDX-1:0] victim_q;

  logic            req, hit, victim_dirty, last_beat;
  logic [WIDX-1:0] hit_way, victim;
  logic [WAYS-1:0] hit_oh, victim_oh;

  assign req          = mem_read | mem_write;
  assign hit          = |hit_vec;
  assign hit_way      = lowest_idx(hit_vec);
  // An invalid way is always preferred over the PLRU choice.
  assign victim       = (&valid_vec) ? plru_victim : lowest_idx(~valid_vec);
  assign victim_dirty = valid_vec[victim] & dirty_vec[victim];
  assign hit_oh       = WAYS'(1) << hit_way;
  assign victim_oh    = WAYS'(1) << victim_q;
  assign last_beat    = (cnt == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      victim_q <= '0;
    end else begin
      state <= state_d;
      if (state == LOOKUP && req && !hit) victim_q <= victim;
      if ((state == WB || state == FILL) && pmem_resp) begin
        cnt <= last_beat ? '0 : cnt + BW'(1);
      end
    end
  end

  always_comb begin
    state_d      = state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    beat_idx     = '0;
    addr_sel     = 1'b0;
    way_sel      = '0;
    ld_data      = '0;
    ld_tag       = '0;
    ld_valid     = '0;
    ld_dirty     = '0;
    data_src_sel = 1'b0;
    dirty_in     = 1'b0;
    ld_plru      = 1'b0;
    unique case (state)
      IDLE: if (req) state_d = LOOKUP;
      LOOKUP: begin
        // A replay whose requester has gone away just retires silently.
        if (!req) begin
          state_d = IDLE;
        end else if (hit) begin
          mem_resp = 1'b1;
          ld_plru  = 1'b1;
          way_sel  = hit_way;
          if (mem_write) begin
            ld_data  = hit_oh;
            ld_dirty = hit_oh;
            dirty_in = 1'b1;
          end
          state_d = IDLE;
        end else begin
          state_d = victim_dirty ? WB : FILL;
        end
      end
      WB: begin
        pmem_write = 1'b1;
        addr_sel   = 1'b1;
        way_sel    = victim_q;
        beat_idx   = cnt;
        if (pmem_resp && last_beat) begin
          ld_dirty = victim_oh;
          state_d  = FILL;
        end
      end
      FILL: begin
        pmem_read    = 1'b1;
        data_src_sel = 1'b1;
        way_sel      = victim_q;
        beat_idx     = cnt;
        if (pmem_resp) begin
          ld_data = victim_oh;
          if (last_beat) begin
            ld_tag   = victim_oh;
            ld_valid = victim_oh;
            ld_dirty = victim_oh;
            state_d  = LOOKUP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef L2_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic replay_q;
  logic first_lookup;

  assign first_lookup = (state == LOOKUP) && req && !replay_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      replay_q   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (state == IDLE) replay_q <= 1'b0;
      else if (state == FILL && state_d == LOOKUP) replay_q <= 1'b1;
      if (first_lookup && hit) hit_count <= sat_inc(hit_count);
      if (first_lookup && !hit) miss_count <= sat_inc(miss_count);
      if (state == LOOKUP && state_d == WB) wb_count <= sat_inc(wb_count);
    end
  end
`else
  // CNT_W only sizes the counters; keep it referenced when they are absent.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule
